fetch: RTL



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 102 ++++++++++
 rtl/fetch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [0:0] {
        RUN           = 1'b0,
        WAIT_REDIRECT = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTRUCTION_BYTES = 4;
    localparam int unsigned MAX_DEPTH         = 4;

    typedef logic [2:0] count_t;
    typedef logic [1:0] ptr_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instruction} FIFO, DEPTH entries (1..4), with full clear and
// a clear that keeps only the head entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  logic    clear,
    input  logic    clear_behind_head,
    input  regval_t push_pc,
    input  regval_t push_instruction,
    output count_t  count,
    output count_t  count_next,
    output regval_t head_pc,
    output regval_t head_instruction
);

    regval_t pc_mem_q    [0:MAX_DEPTH-1];
    regval_t pc_mem_d    [0:MAX_DEPTH-1];
    regval_t instr_mem_q [0:MAX_DEPTH-1];
    regval_t instr_mem_d [0:MAX_DEPTH-1];
    ptr_t    rd_ptr_q, rd_ptr_d;
    ptr_t    wr_ptr_q, wr_ptr_d;
    count_t  count_q,  count_d;

    // Storage is always MAX_DEPTH wide; pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == ptr_t'(DEPTH - 1)) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    // Next-state pointers, occupancy and storage.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (clear) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = 3'd0;
        end else if (clear_behind_head) begin
            if (count_q == 3'd0) begin
                wr_ptr_d = rd_ptr_q;
                count_d  = 3'd0;
            end else if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                wr_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = 3'd0;
            end else begin
                wr_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = 3'd1;
            end
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = push_pc;
                instr_mem_d[wr_ptr_q] = push_instruction;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // FIFO state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0000_0000;
                instr_mem_q[i] <= 32'h0000_0000;
            end
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign count            = count_q;
    assign count_next       = count_d;
    assign head_pc          = pc_mem_q[rd_ptr_q];
    assign head_instruction = instr_mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, pipelined imem reads, response FIFO toward decode.
// Optional FETCH_RESPONSE_BYPASS_EN presents a response in its arrival cycle.
module fetch
    import fetch_pkg::*;
#(
    parameter regval_t     RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hold,
    output logic        is_valid,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    input  logic        is_pc_changing,
    input  logic        early_flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [29:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    input  logic        imem_readdatavalid
);

    fetch_state_t state_q, state_d;
    regval_t      fetch_pc_q, fetch_pc_d;
    regval_t      resp_pc_q, resp_pc_d;
    count_t       outstanding_q, outstanding_d;
    count_t       discard_q, discard_d;
    logic         read_q, read_d;
    logic [29:0]  addr_q, addr_d;
    logic         stale_req_q, stale_req_d;

    logic         accept_s, flush_s, clear_s, bypass_s, stale_s, take_s;
    logic         push_s, pop_s, cbh_s, req_stall_s, not_empty_s;
    count_t       out_after_s, fifo_count_s, fifo_count_next_s;
    regval_t      head_pc_s, head_instr_s, redirect_target_s;
    logic         unused_redirect_bits_s;

    assign redirect_target_s      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits_s = ^redirect_pc[1:0];
    assign not_empty_s            = (fifo_count_s != 3'd0);

    // Flow control: which response is kept, what the FIFO does, and the next fetch state.
    always_comb begin
        accept_s    = read_q && !imem_waitrequest;
        req_stall_s = read_q && imem_waitrequest;
        clear_s     = redirect_valid || early_flush;
        flush_s     = clear_s || is_pc_changing;
`ifdef FETCH_RESPONSE_BYPASS_EN
        bypass_s    = imem_readdatavalid && (discard_q == 3'd0) && !not_empty_s && !clear_s;
`else
        bypass_s    = 1'b0;
`endif
        // A response arriving alongside a flush is stale unless it is the word decode is looking at.
        stale_s     = clear_s || (is_pc_changing && !bypass_s);
        take_s      = imem_readdatavalid && (discard_q == 3'd0) && !stale_s;
        push_s      = take_s && !(bypass_s && !hold);
        pop_s       = not_empty_s && !hold;
        cbh_s       = is_pc_changing && !clear_s && not_empty_s;
        out_after_s = outstanding_q + {2'b00, accept_s} - {2'b00, imem_readdatavalid};

        outstanding_d = out_after_s;
        if (flush_s) begin
            discard_d = out_after_s;
        end else if (imem_readdatavalid && (discard_q != 3'd0)) begin
            discard_d = discard_q - 3'd1 + {2'b00, accept_s && stale_req_q};
        end else begin
            discard_d = discard_q + {2'b00, accept_s && stale_req_q};
        end

        if (accept_s) begin
            stale_req_d = 1'b0;
        end else if (flush_s && read_q) begin
            stale_req_d = 1'b1;
        end else begin
            stale_req_d = stale_req_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_target_s;
            resp_pc_d  = redirect_target_s;
        end else begin
            fetch_pc_d = (accept_s && !stale_req_q) ?
                         fetch_pc_q + regval_t'(INSTRUCTION_BYTES) : fetch_pc_q;
            resp_pc_d  = take_s ? resp_pc_q + regval_t'(INSTRUCTION_BYTES) : resp_pc_q;
        end

        if (redirect_valid) begin
            state_d = RUN;
        end else if (early_flush || is_pc_changing) begin
            state_d = WAIT_REDIRECT;
        end else begin
            state_d = state_q;
        end

        // Issue decision for next cycle uses the post-edge counts, i.e. registered values then.
        if (req_stall_s) begin
            read_d = 1'b1;
            addr_d = addr_q;
        end else begin
            read_d = (state_d == RUN) &&
                     (({1'b0, outstanding_d} + {1'b0, fifo_count_next_s}) < 4'(DEPTH));
            addr_d = fetch_pc_d[31:2];
        end
    end

    // Fetch control registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= 3'd0;
            discard_q     <= 3'd0;
            read_q        <= 1'b0;
            addr_q        <= RESET_PC[31:2];
            stale_req_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            stale_req_q   <= stale_req_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock             (clock),
        .reset_n           (reset_n),
        .push              (push_s),
        .pop               (pop_s),
        .clear             (clear_s),
        .clear_behind_head (cbh_s),
        .push_pc           (resp_pc_q),
        .push_instruction  (imem_readdata),
        .count             (fifo_count_s),
        .count_next        (fifo_count_next_s),
        .head_pc           (head_pc_s),
        .head_instruction  (head_instr_s)
    );

    // Decode-facing outputs come from the FIFO head (or the arriving word when bypassing).
    always_comb begin
        is_valid = not_empty_s || bypass_s;
        if (not_empty_s) begin
            pc          = head_pc_s;
            instruction = head_instr_s;
        end else if (bypass_s) begin
            pc          = resp_pc_q;
            instruction = imem_readdata;
        end else begin
            pc          = 32'h0000_0000;
            instruction = 32'h0000_0000;
        end
    end

    assign imem_read    = read_q;
    assign imem_address = addr_q;

endmodule
